// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARMv4 main controller.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// Data-processing field decode to ALU op, flag-write mask and no-write flag.
// Optional CMP decode is enabled by defining CMP_DECODE_EN.
module alu_decoder
  import arm_ctrl_pkg::*;
(
  input  logic       i_alu_op,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w,
  output logic       o_no_write
);

  logic [3:0] w_cmd;
  logic       w_s;
  logic [1:0] w_ctl;
  logic [1:0] w_flags;
  logic       w_no_write;

  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    w_ctl      = ALU_ADD;
    w_flags    = 2'b00;
    w_no_write = 1'b0;
    case (w_cmd)
      CMD_ADD: begin w_ctl = ALU_ADD; w_flags = {w_s, w_s};  end
      CMD_SUB: begin w_ctl = ALU_SUB; w_flags = {w_s, w_s};  end
      CMD_AND: begin w_ctl = ALU_AND; w_flags = {w_s, 1'b0}; end
      CMD_ORR: begin w_ctl = ALU_ORR; w_flags = {w_s, 1'b0}; end
`ifdef CMP_DECODE_EN
      CMD_CMP: begin
        w_no_write = 1'b1;
        if (w_s) begin
          w_ctl   = ALU_SUB;
          w_flags = 2'b11;
        end
      end
`endif
      default: w_no_write = 1'b1;
    endcase
  end

  // NoWrite stays live outside the execute state: ALUWB needs it a cycle later.
  assign o_alu_control = i_alu_op ? w_ctl : ALU_ADD;
  assign o_flag_w      = i_alu_op ? w_flags : 2'b00;
  assign o_no_write    = w_no_write;

endmodule

// File: rtl/control_fsm.sv
// Multicycle ARMv4 main controller: fetch/decode/execute sequencing and raw strobes.
// Define CMP_DECODE_EN to decode cmd 1010 with S=1 as CMP.
module control_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  state_t     r_state;
  state_t     w_next;
  logic       w_next_pc, w_ir_write, w_reg_w, w_mem_w, w_branch, w_alu_op;
  logic       w_no_write;
  logic [1:0] w_flag_w;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_next_pc  = 1'b0;
    w_ir_write = 1'b0;
    w_reg_w    = 1'b0;
    w_mem_w    = 1'b0;
    w_branch   = 1'b0;
    w_alu_op   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_next_pc  = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        w_reg_w   = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        w_mem_w = 1'b1;
      end
      S_EXECUTER: w_alu_op = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB  = SRCB_IMM;
        w_alu_op = 1'b1;
      end
      S_ALUWB:    w_reg_w = ~w_no_write;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (Funct),
    .o_alu_control (ALUControl),
    .o_flag_w      (w_flag_w),
    .o_no_write    (w_no_write)
  );

  // Strobes are suppressed while reset is held; mux selects already sit at FETCH values.
  assign NextPC  = rst & w_next_pc;
  assign IRWrite = rst & w_ir_write;
  assign RegW    = rst & w_reg_w;
  assign MemW    = rst & w_mem_w;
  assign PCS     = rst & (w_branch | (w_reg_w & (Rd == 4'hF)));
  assign FlagW   = rst ? w_flag_w : 2'b00;
  assign ImmSrc  = Op;
  assign RegSrc  = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle ARMv4 main controller: sequences each instruction through fetch, decode and execute states and produces the raw, unconditioned control strobes (PCS, RegW, MemW, FlagW) that the condition-check unit gates with CondEx. It also drives the datapath mux selects and the ALU operation. It sits between the instruction register and the condition logic, and it is the producer side of that PCS/RegW/MemW/FlagW interface.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- Op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S for data-processing or L for memory
- Rd  in  4  instr[15:12]
- NextPC  out  1  unconditional PC write
- IRWrite  out  1  instruction register load
- PCS  out  1  raw PC-source request
- RegW  out  1  raw register write
- MemW  out  1  raw memory write
- FlagW  out  2  raw flag write: [1]=N,Z; [0]=C,V
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALU
- ALUSrcA  out  1  ALU A select: 0=Rn, 1=PC
- ALUSrcB  out  2  ALU B select: 00 reg, 01 imm, 10 constant 4
- ALUControl  out  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH→DECODE.
- DECODE transitions:
  - Op=01 → MEMADR
  - Op=00 with I=0 → EXECUTER; with I=1 → EXECUTEI
  - Op=10 → BRANCH
  - Op=11 → FETCH (NOP)
- MEMADR → MEMREAD if L=1, otherwise MEMWRITE.
- MEMREAD→MEMWB→FETCH. MEMWRITE→FETCH. EXECUTER/EXECUTEI→ALUWB→FETCH. BRANCH→FETCH.
- Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcA=0, ALUSrcB=01
  - MEMREAD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWRITE: AdrSrc=1, MemW=1
  - EXECUTER: ALUSrcB=00, ALUOp active
  - EXECUTEI: ALUSrcB=01, ALUOp active
  - ALUWB: ResultSrc=00, RegW=1 (unless NoWrite)
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1
- PCS = Branch | (RegW & Rd==4'hF).
- ALU decode applies only while ALUOp is active; otherwise ALUControl=00 and FlagW=00.
  - cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - FlagW[1]=S. FlagW[0]=S & (ADD|SUB).
  - Any other cmd: ALUControl=00, FlagW=00, NoWrite=1.
- Op, Funct and Rd are stable from DECODE through the end of the instruction; the IR holds them. The block does not latch them.

## Timing
- Next state is registered; all outputs are combinational from state, Op, Funct and Rd (Moore plus field decode).
- Instruction lengths in cycles: LDR 5, STR 4, data-processing 4, B 3, Op=11 2.
- Reset:
  - rst low asynchronously forces state to FETCH.
  - While rst is low, NextPC, IRWrite, PCS, RegW, MemW and FlagW are forced to 0. Mux selects hold their FETCH values.
  - The first rising edge after rst rises performs the fetch.
- Reset mid-instruction: the current instruction is abandoned with no partial RegW or MemW.

## Configuration
- CMP_DECODE_EN defined: cmd 1010 with S=1 decodes as CMP.
  - ALUControl=01, FlagW=11, NoWrite=1, so ALUWB has RegW=0 and PCS=0.
- CMP_DECODE_EN undefined: cmd 1010 falls into the "other cmd" rule (no flags, no write).

## Structure
- Shared package arm_ctrl_pkg holds:
  - state enum
  - ALUControl encodings
  - Op encodings
  - ResultSrc and ALUSrcB encodings
- Sub-module alu_decoder: combinational mapping (ALUOp, Funct) → ALUControl, FlagW, NoWrite.

## Test plan
- Reset released, Op=00, Funct=001000 (ADD, I=0, S=0), Rd=3:
  - states FETCH, DECODE, EXECUTER, ALUWB
  - RegW=1 only in ALUWB, FlagW=00, PCS=0
- LDR (Op=01, Funct[0]=1, Rd=15):
  - 5-cycle sequence
  - MEMWB has ResultSrc=01, RegW=1, PCS=1
- STR (Op=01, L=0):
  - MEMWRITE has AdrSrc=1, MemW=1, RegW=0
  - back in FETCH after 4 cycles
- SUBS register form (Funct=000101): EXECUTER has ALUControl=01, FlagW=11. ORRS register form (Funct=011001): FlagW=10.
- B (Op=10): BRANCH has PCS=1, ALUSrcB=01. Op=11 returns to FETCH after DECODE with no strobes.
- Mid-instruction reset and CMP decode:
  - rst pulsed low during MEMWRITE: MemW drops immediately, state is FETCH, IRWrite=0 until release.
  - With CMP_DECODE_EN, CMP (Funct=010101) gives ALUWB with RegW=0 and FlagW=11 in EXECUTER.
